// File: rtl/aes_pkg.sv
// Shared AES-128 constants for the inverse key-expansion block: round count,
// controller state encoding, round constants and the forward S-box.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        BWD  = 2'd2
    } state_t;

    // Entry 0 and 11..15 are never used as a real round constant and read as zero.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 2047 - 8 * int'(b);
        return SBOX_FLAT[idx -: 8];
    endfunction

    function automatic logic [31:0] rcon_word(input logic [3:0] r);
        return {RCON[r], 24'h000000};
    endfunction

endpackage

// File: rtl/inv_key_expansion_if.sv
// Load / step / round-key bus between a controller and inv_key_expansion.
interface inv_key_expansion_if;
    logic         Valid;
    logic [127:0] Key_in;
    logic         En_Exp;
    logic [127:0] key_rndn;
    logic [3:0]   rnd_num;
    logic         Key_Ready;
    logic         Busy;

    modport master (
        output Valid, Key_in, En_Exp,
        input  key_rndn, rnd_num, Key_Ready, Busy
    );

    modport slave (
        input  Valid, Key_in, En_Exp,
        output key_rndn, rnd_num, Key_Ready, Busy
    );
endinterface

// File: rtl/inv_key_expansion_g_func.sv
// AES key-schedule g(): RotWord, SubWord, then xor the round constant into the top byte.
module inv_key_expansion_g_func
    import aes_pkg::*;
(
    input  logic [31:0] w,
    input  logic [3:0]  rnd,
    output logic [31:0] g
);

    logic [31:0] sub_rot;

    assign sub_rot = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    assign g       = sub_rot ^ rcon_word(rnd);

endmodule

// File: rtl/inv_key_expansion.sv
// AES-128 round-key walker: runs forward to the round-10 key after a load, then steps
// back one round per En_Exp so a decryptor can consume keys 10..0 in order.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no valid decryption key; waits for Valid
//   FWD   | forward pre-computation, one round per cycle (Busy)
//   BWD   | key_rndn valid, steps to previous round on En_Exp (Key_Ready)
module inv_key_expansion
    import aes_pkg::*;
(
    input  logic                CLK,
    input  logic                rst_n,
    inv_key_expansion_if.slave  bus
);

    state_t       state, state_nxt;
    logic [127:0] key_q, key_nxt;
    logic [3:0]   rnd_q, rnd_nxt;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] g_in, g_out;
    logic [3:0]  g_rnd;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // Single g() shared by both directions; the previous-key path feeds it its own P3.
    assign p3    = w3 ^ w2;
    assign g_in  = (state == FWD) ? w3 : p3;
    assign g_rnd = (state == FWD) ? (rnd_q + 4'd1) : rnd_q;

    inv_key_expansion_g_func u_g_func (
        .w   (g_in),
        .rnd (g_rnd),
        .g   (g_out)
    );

    assign f0 = w0 ^ g_out;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign p0 = w0 ^ g_out;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            key_q <= '0;
            rnd_q <= '0;
        end else begin
            state <= state_nxt;
            key_q <= key_nxt;
            rnd_q <= rnd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        key_nxt   = key_q;
        rnd_nxt   = rnd_q;
        if (bus.Valid) begin
            state_nxt = FWD;
            key_nxt   = bus.Key_in;
            rnd_nxt   = 4'd0;
        end else begin
            case (state)
                FWD: begin
                    key_nxt = {f0, f1, f2, f3};
                    rnd_nxt = rnd_q + 4'd1;
                    if (rnd_q >= 4'(NUM_ROUNDS - 1)) begin
                        state_nxt = BWD;
                        rnd_nxt   = 4'(NUM_ROUNDS);
                    end
                end
                BWD: begin
                    if (bus.En_Exp) begin
                        if (rnd_q != 4'd0) begin
                            key_nxt = {p0, p1, p2, p3};
                            rnd_nxt = rnd_q - 4'd1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                IDLE: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.key_rndn  = key_q;
    assign bus.rnd_num   = rnd_q;
    assign bus.Busy      = (state == FWD);
    assign bus.Key_Ready = (state == BWD);

endmodule

// File: tb/tb_inv_key_expansion.sv
// Bench for inv_key_expansion: directed known-answer sequences plus randomized
// load/step traffic checked against a textbook AES-128 key schedule.
module tb_inv_key_expansion;

    logic CLK = 1'b0;
    logic rst_n;
    inv_key_expansion_if bus ();

    inv_key_expansion dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef enum {M_IDLE, M_FWD, M_BWD} mmode_t;
    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   rnd;
    } exp_t;

    exp_t         sb_q[$];
    logic [7:0]   sbox_t [256];
    logic [127:0] rk [11];
    mmode_t       m_mode = M_IDLE;
    logic [3:0]   m_rnd  = 4'd0;
    logic [127:0] m_key  = '0;

    localparam logic [127:0] KA      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KA_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KA_R9   = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] KA_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KZ_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int j = 1; j < 256; j++)
                if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            b = inv;
            sbox_t[i] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One clock of stimulus; the behavioural model advances alongside and
    // queues every round key the DUT is expected to present in BWD.
    task automatic step(input logic v, input logic [127:0] k, input logic e);
        bus.Valid  = v;
        bus.Key_in = k;
        bus.En_Exp = e;
        if (v) begin
            if (m_mode == M_FWD && sb_q.size() > 0) void'(sb_q.pop_back());
            expand(k);
            sb_q.push_back('{key: rk[10], rnd: 4'd10});
            m_mode = M_FWD;
            m_rnd  = 4'd0;
            m_key  = k;
        end else if (m_mode == M_FWD) begin
            m_rnd = m_rnd + 4'd1;
            m_key = rk[m_rnd];
            if (m_rnd == 4'd10) m_mode = M_BWD;
        end else if (m_mode == M_BWD && e) begin
            if (m_rnd > 0) begin
                m_rnd = m_rnd - 4'd1;
                m_key = rk[m_rnd];
                sb_q.push_back('{key: m_key, rnd: m_rnd});
            end else begin
                m_mode = M_IDLE;
            end
        end
        @(posedge CLK);
        #1;
        chk("busy",      128'(bus.Busy),      128'(m_mode == M_FWD));
        chk("key_ready", 128'(bus.Key_Ready), 128'(m_mode == M_BWD));
        chk("rnd_num",   128'(bus.rnd_num),   128'(m_rnd));
        chk("key_rndn",  bus.key_rndn,        m_key);
        bus.Valid  = 1'b0;
        bus.Key_in = '0;
        bus.En_Exp = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_key",   bus.key_rndn,        128'h0);
        chk("rst_rnd",   128'(bus.rnd_num),   128'h0);
        chk("rst_ready", 128'(bus.Key_Ready), 128'h0);
        chk("rst_busy",  128'(bus.Busy),      128'h0);
        m_mode = M_IDLE;
        m_rnd  = 4'd0;
        m_key  = '0;
        sb_q.delete();
        @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    logic       prev_rdy = 1'b0;
    logic [3:0] prev_rnd = 4'd0;
    exp_t       got;

    always @(negedge CLK) begin
        if (rst_n && bus.Key_Ready && (!prev_rdy || bus.rnd_num != prev_rnd)) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got rnd %0d key %h expected no output",
                         bus.rnd_num, bus.key_rndn);
            end else begin
                got = sb_q.pop_front();
                chk("sb_key", bus.key_rndn,      got.key);
                chk("sb_rnd", 128'(bus.rnd_num), 128'(got.rnd));
            end
        end
        prev_rdy = bus.Key_Ready;
        prev_rnd = bus.rnd_num;
    end

    initial begin
        rst_n      = 1'b0;
        bus.Valid  = 1'b0;
        bus.Key_in = '0;
        bus.En_Exp = 1'b0;
        build_sbox();
        repeat (2) @(posedge CLK);
        #1;
        chk("init_key",   bus.key_rndn,        128'h0);
        chk("init_rnd",   128'(bus.rnd_num),   128'h0);
        chk("init_ready", 128'(bus.Key_Ready), 128'h0);
        chk("init_busy",  128'(bus.Busy),      128'h0);
        @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;

        // Known-answer walk down the FIPS-197 example schedule.
        step(1'b1, KA, 1'b0);
        repeat (10) step(1'b0, '0, 1'b0);
        chk("kat_r10", bus.key_rndn, KA_R10);
        step(1'b0, '0, 1'b1);
        chk("kat_r9", bus.key_rndn, KA_R9);
        repeat (8) step(1'b0, '0, 1'b1);
        chk("kat_r1", bus.key_rndn, KA_R1);
        step(1'b0, '0, 1'b1);
        chk("kat_r0", bus.key_rndn, KA);
        step(1'b0, '0, 1'b1);
        chk("idle_ready", 128'(bus.Key_Ready), 128'h0);
        chk("idle_key",   bus.key_rndn,        KA);
        repeat (3) step(1'b0, '0, 1'b1);
        chk("idle_hold", bus.key_rndn, KA);

        // Abort mid-forward with the all-zero key.
        step(1'b1, KA, 1'b0);
        repeat (5) step(1'b0, '0, 1'b1);
        step(1'b1, '0, 1'b0);
        repeat (10) step(1'b0, '0, 1'b0);
        chk("zero_r10", bus.key_rndn, KZ_R10);

        // Reset in the middle of the backward walk.
        repeat (4) step(1'b0, '0, 1'b1);
        chk("bwd_at6", 128'(bus.rnd_num), 128'd6);
        async_reset();
        step(1'b0, '0, 1'b1);
        chk("post_rst_key", bus.key_rndn, 128'h0);

        // Load and step together in BWD: load wins.
        step(1'b1, KA, 1'b0);
        repeat (12) step(1'b0, '0, 1'b0);
        step(1'b1, 128'h00112233445566778899aabbccddeeff, 1'b1);
        chk("ld_win_busy", 128'(bus.Busy),    128'd1);
        chk("ld_win_rnd",  128'(bus.rnd_num), 128'd0);
        repeat (12) step(1'b0, '0, 1'b1);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 19) == 0,
                     {$urandom, $urandom, $urandom, $urandom},
                     $urandom_range(0, 1) == 1);
            end
        end

        repeat (3) step(1'b0, '0, 1'b0);
        @(negedge CLK);
        #1;
        while (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL sb_missing: got nothing expected rnd %0d key %h", got.rnd, got.key);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_key_expansion.md
INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

Interface
REQ-001 Parameter: none; AES-128 only, NUM_ROUNDS=10 fixed.
REQ-002 CLK  in  1  rising-edge clock, single domain.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 Valid  in  1  load pulse; Key_in sampled on that edge.
REQ-005 Key_in  in  128  cipher key (round-0 key), byte 0 = [127:120].
REQ-006 En_Exp  in  1  step key_rndn to previous round key.
REQ-007 key_rndn  out  128  registered current round key, word 0 = [127:96].
REQ-008 rnd_num  out  4  round index of key_rndn (0..10).
REQ-009 Key_Ready  out  1  high while key_rndn is a valid decryption key.
REQ-010 Busy  out  1  high while the forward pre-computation runs.

Function
REQ-011 FSM states SHALL be IDLE, FWD, BWD.
REQ-012 Valid in any state SHALL load Key_in into key_rndn, set rnd_num=0, enter FWD; Valid beats En_Exp.
REQ-013 FWD: each cycle key_rndn <= forward next key (w0'=w0^g(w3,rcon[rnd_num+1]), wi'=wi^w(i-1)'), rnd_num++.
REQ-014 FWD->BWD SHALL occur on the edge where rnd_num becomes 10: Key_Ready high 10 edges after the Valid-sampling edge, key_rndn = round-10 key.
REQ-015 BWD with En_Exp and rnd_num>0: key_rndn <= previous key (P3=K3^K2, P2=K2^K1, P1=K1^K0, P0=K0^g(P3,rcon[rnd_num])), rnd_num--.
REQ-016 BWD with En_Exp and rnd_num=0: enter IDLE, Key_Ready low, key_rndn and rnd_num held.
REQ-017 En_Exp SHALL be ignored in IDLE and FWD; no step without En_Exp in BWD (key held indefinitely).
REQ-018 Busy SHALL equal (state==FWD); Key_Ready SHALL equal (state==BWD); both registered-state decodes, no combinational path from inputs.
REQ-019 rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 in the top byte, lower 24 bits zero.
REQ-020 Valid during FWD or BWD SHALL abort the sequence and restart from the new Key_in with no stale round key visible.
REQ-021 rnd_num SHALL never exceed 10 nor wrap below 0.

Reset
REQ-022 Reset SHALL force state=IDLE, key_rndn=0, rnd_num=0, Key_Ready=0, Busy=0, asynchronously.
REQ-023 Reset mid-FWD or mid-BWD SHALL discard progress; first post-reset action needs Valid.

Structure
REQ-024 aes_pkg SHALL hold NUM_ROUNDS, the FSM state enum and the RCON table.
REQ-025 One G_func instance SHALL be shared: input muxed w3 (FWD) / K3^K2 (BWD), round index rnd_num+1 (FWD) / rnd_num (BWD).
REQ-026 Next-key and previous-key datapaths SHALL be combinational, single 128-bit key register plus 4-bit counter.

Verification
REQ-027 Key_in=2b7e151628aed2a6abf7158809cf4f3c, Valid 1 cycle -> 10 edges later Key_Ready=1, rnd_num=10, key_rndn=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-028 Then En_Exp once -> rnd_num=9, key_rndn=ac7766f319fadc2128d12941575c006e; 8 more -> rnd_num=1, key_rndn=a0fafe1788542cb123a339392a6c7605; one more -> rnd_num=0, key_rndn=Key_in.
REQ-029 At rnd_num=0 En_Exp -> IDLE, Key_Ready=0, key_rndn unchanged; further En_Exp -> no change.
REQ-030 Valid with key A, then at FWD rnd_num=5 Valid with key 000...0 -> Key_Ready after 10 edges with round-10 key of all-zero key (b4ef5bcb3e92e21123e951cf6f8f188e).
REQ-031 rst_n low mid-BWD (rnd_num=6) -> immediately key_rndn=0, rnd_num=0, Key_Ready=0, Busy=0; En_Exp after release -> no change.
REQ-032 Valid and En_Exp together in BWD -> load wins, Busy=1, rnd_num=0.
